// File: rtl/reg_bus_arbiter.sv
// Two-requester arbiter for the register-file port: round-robin grant, single
// registered request per access, ack timeout, registered completion back to the winner.
module reg_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_rnw,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_err,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              fsm_req,
  input  logic [ADDR_W-1:0] fsm_addr,
  input  logic              fsm_rnw,
  input  logic [DATA_W-1:0] fsm_wdata,
  output logic              fsm_ack,
  output logic              fsm_err,
  output logic [DATA_W-1:0] fsm_rdata,
  output logic              reg_req,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rnw,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              grant_host,
  output logic              grant_fsm,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                last_host_q, last_host_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                reg_req_q, reg_req_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic                reg_rnw_q, reg_rnw_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                host_ack_q, host_ack_d;
  logic                host_err_q, host_err_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                fsm_ack_q, fsm_ack_d;
  logic                fsm_err_q, fsm_err_d;
  logic [DATA_W-1:0]   fsm_rdata_q, fsm_rdata_d;
  logic                grant_host_q, grant_host_d;
  logic                grant_fsm_q, grant_fsm_d;
  logic                busy_q, busy_d;

  logic                fin;
  logic                fin_err;
  logic [DATA_W-1:0]   fin_data;

  always_comb begin
    state_d      = state_q;
    last_host_d  = last_host_q;
    cnt_d        = cnt_q;
    reg_req_d    = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_rnw_d    = reg_rnw_q;
    reg_wdata_d  = reg_wdata_q;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    host_rdata_d = '0;
    fsm_ack_d    = 1'b0;
    fsm_err_d    = 1'b0;
    fsm_rdata_d  = '0;
    grant_host_d = grant_host_q;
    grant_fsm_d  = grant_fsm_q;
    busy_d       = busy_q;
    fin          = 1'b0;
    fin_err      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie the requester not served last wins.
        if (host_req && (!fsm_req || !last_host_q)) begin
          state_d      = S_ISSUE;
          last_host_d  = 1'b1;
          cnt_d        = '0;
          reg_req_d    = 1'b1;
          reg_addr_d   = host_addr;
          reg_rnw_d    = host_rnw;
          reg_wdata_d  = host_wdata;
          grant_host_d = 1'b1;
          busy_d       = 1'b1;
        end else if (fsm_req) begin
          state_d      = S_ISSUE;
          last_host_d  = 1'b0;
          cnt_d        = '0;
          reg_req_d    = 1'b1;
          reg_addr_d   = fsm_addr;
          reg_rnw_d    = fsm_rnw;
          reg_wdata_d  = fsm_wdata;
          grant_fsm_d  = 1'b1;
          busy_d       = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (reg_ack) fin = 1'b1;
        else         state_d = S_WAIT;
      end
      S_WAIT: begin
        if (reg_ack) begin
          fin = 1'b1;
        end else if (cnt_q == TIMEOUT_C) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        grant_host_d = 1'b0;
        grant_fsm_d  = 1'b0;
        busy_d       = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Writes and timeouts return zero data.
    fin_data = (fin_err || !reg_rnw_q) ? '0 : reg_rdata;
    if (fin) begin
      state_d = S_DONE;
      if (grant_host_q) begin
        host_ack_d   = 1'b1;
        host_err_d   = fin_err;
        host_rdata_d = fin_data;
      end else begin
        fsm_ack_d    = 1'b1;
        fsm_err_d    = fin_err;
        fsm_rdata_d  = fin_data;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_host_q  <= 1'b0;
      cnt_q        <= '0;
      reg_req_q    <= 1'b0;
      reg_addr_q   <= '0;
      reg_rnw_q    <= 1'b0;
      reg_wdata_q  <= '0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
      fsm_ack_q    <= 1'b0;
      fsm_err_q    <= 1'b0;
      fsm_rdata_q  <= '0;
      grant_host_q <= 1'b0;
      grant_fsm_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_host_q  <= last_host_d;
      cnt_q        <= cnt_d;
      reg_req_q    <= reg_req_d;
      reg_addr_q   <= reg_addr_d;
      reg_rnw_q    <= reg_rnw_d;
      reg_wdata_q  <= reg_wdata_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
      fsm_ack_q    <= fsm_ack_d;
      fsm_err_q    <= fsm_err_d;
      fsm_rdata_q  <= fsm_rdata_d;
      grant_host_q <= grant_host_d;
      grant_fsm_q  <= grant_fsm_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_req    = reg_req_q;
  assign reg_addr   = reg_addr_q;
  assign reg_rnw    = reg_rnw_q;
  assign reg_wdata  = reg_wdata_q;
  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;
  assign fsm_ack    = fsm_ack_q;
  assign fsm_err    = fsm_err_q;
  assign fsm_rdata  = fsm_rdata_q;
  assign grant_host = grant_host_q;
  assign grant_fsm  = grant_fsm_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: inputs change 1ns after a rising edge,
// outputs are checked at that same point (after the edge has settled).
module tb_reg_bus_arbiter;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        host_req = 1'b0;
  logic [7:0]  host_addr = '0;
  logic        host_rnw = 1'b0;
  logic [15:0] host_wdata = '0;
  logic        host_ack, host_err;
  logic [15:0] host_rdata;
  logic        fsm_req = 1'b0;
  logic [7:0]  fsm_addr = '0;
  logic        fsm_rnw = 1'b0;
  logic [15:0] fsm_wdata = '0;
  logic        fsm_ack, fsm_err;
  logic [15:0] fsm_rdata;
  logic        reg_req, reg_rnw;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;
  logic        grant_host, grant_fsm, busy;

  int checks = 0;
  int failures = 0;

  reg_bus_arbiter dut (
    .CLK(CLK), .reset(reset),
    .host_req(host_req), .host_addr(host_addr), .host_rnw(host_rnw), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .fsm_req(fsm_req), .fsm_addr(fsm_addr), .fsm_rnw(fsm_rnw), .fsm_wdata(fsm_wdata),
    .fsm_ack(fsm_ack), .fsm_err(fsm_err), .fsm_rdata(fsm_rdata),
    .reg_req(reg_req), .reg_addr(reg_addr), .reg_rnw(reg_rnw), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .grant_host(grant_host), .grant_fsm(grant_fsm), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({reg_req, reg_addr, reg_rnw, reg_wdata} !== 26'h0) begin
      failures++; $display("FAIL reset_regbus got=%h exp=0", {reg_req, reg_addr, reg_rnw, reg_wdata});
    end
    checks++;
    if ({host_ack, host_err, host_rdata, fsm_ack, fsm_err, fsm_rdata, grant_host, grant_fsm, busy} !== 39'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0",
        {host_ack, host_err, host_rdata, fsm_ack, fsm_err, fsm_rdata, grant_host, grant_fsm, busy});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_host_read_immediate();
    host_req = 1'b1; host_addr = 8'h10; host_rnw = 1'b1;
    tick();
    checks++;
    if ({reg_req, reg_addr, reg_rnw, grant_host, grant_fsm, busy, host_ack} !== {1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL t1_issue got req=%b addr=%h rnw=%b gh=%b gf=%b busy=%b ack=%b exp 1 10 1 1 0 1 0",
        reg_req, reg_addr, reg_rnw, grant_host, grant_fsm, busy, host_ack);
    end
    reg_ack = 1'b1; reg_rdata = 16'hBEEF;
    tick();
    checks++;
    if ({host_ack, host_err, host_rdata, fsm_ack, reg_req} !== {1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0}) begin
      failures++; $display("FAIL t1_done got ack=%b err=%b rdata=%h fsm_ack=%b reg_req=%b exp 1 0 beef 0 0",
        host_ack, host_err, host_rdata, fsm_ack, reg_req);
    end
    host_req = 1'b0; reg_ack = 1'b0;
    tick();
    checks++;
    if ({host_ack, busy, grant_host, reg_req} !== 4'b0000) begin
      failures++; $display("FAIL t1_idle got ack=%b busy=%b gh=%b req=%b exp 0000", host_ack, busy, grant_host, reg_req);
    end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; tick(); reset = 1'b0;
    host_req = 1'b1; host_addr = 8'h20; host_rnw = 1'b1;
    fsm_req  = 1'b1; fsm_addr  = 8'h30; fsm_rnw  = 1'b1;
    reg_ack = 1'b1; reg_rdata = 16'h1234;
    tick();
    checks++;
    if ({grant_host, grant_fsm, reg_req, reg_addr} !== {3'b101, 8'h20}) begin
      failures++; $display("FAIL t2_first_grant got gh=%b gf=%b req=%b addr=%h exp 1 0 1 20", grant_host, grant_fsm, reg_req, reg_addr);
    end
    tick();
    checks++;
    if ({host_ack, fsm_ack, host_rdata} !== {2'b10, 16'h1234}) begin
      failures++; $display("FAIL t2_first_ack got h=%b f=%b rd=%h exp 1 0 1234", host_ack, fsm_ack, host_rdata);
    end
    tick();
    checks++;
    if ({busy, grant_host, grant_fsm, reg_req} !== 4'b0000) begin
      failures++; $display("FAIL t2_gap got busy=%b gh=%b gf=%b req=%b exp 0000", busy, grant_host, grant_fsm, reg_req);
    end
    tick();
    checks++;
    if ({grant_host, grant_fsm, reg_req, reg_addr} !== {3'b011, 8'h30}) begin
      failures++; $display("FAIL t2_second_grant got gh=%b gf=%b req=%b addr=%h exp 0 1 1 30", grant_host, grant_fsm, reg_req, reg_addr);
    end
    tick();
    checks++;
    if ({host_ack, fsm_ack, fsm_rdata, host_rdata} !== {2'b01, 16'h1234, 16'h0}) begin
      failures++; $display("FAIL t2_second_ack got h=%b f=%b frd=%h hrd=%h exp 0 1 1234 0", host_ack, fsm_ack, fsm_rdata, host_rdata);
    end
    tick();
    tick();
    checks++;
    if ({grant_host, grant_fsm, reg_req, reg_addr} !== {3'b101, 8'h20}) begin
      failures++; $display("FAIL t2_third_grant got gh=%b gf=%b req=%b addr=%h exp 1 0 1 20", grant_host, grant_fsm, reg_req, reg_addr);
    end
    host_req = 1'b0; fsm_req = 1'b0;
    tick();
    checks++;
    if ({host_ack, fsm_ack} !== 2'b10) begin
      failures++; $display("FAIL t2_third_ack got h=%b f=%b exp 1 0", host_ack, fsm_ack);
    end
    reg_ack = 1'b0;
    tick();
  endtask

  task automatic test_fsm_write_delayed();
    fsm_req = 1'b1; fsm_addr = 8'h1A; fsm_rnw = 1'b0; fsm_wdata = 16'h0055;
    tick();
    checks++;
    if ({reg_req, reg_addr, reg_rnw, reg_wdata, grant_fsm, grant_host} !== {1'b1, 8'h1A, 1'b0, 16'h0055, 2'b10}) begin
      failures++; $display("FAIL t3_issue got req=%b addr=%h rnw=%b wd=%h gf=%b gh=%b exp 1 1a 0 0055 1 0",
        reg_req, reg_addr, reg_rnw, reg_wdata, grant_fsm, grant_host);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({reg_req, reg_wdata, busy, fsm_ack} !== {1'b0, 16'h0055, 1'b1, 1'b0}) begin
        failures++; $display("FAIL t3_wait%0d got req=%b wd=%h busy=%b ack=%b exp 0 0055 1 0", i, reg_req, reg_wdata, busy, fsm_ack);
      end
    end
    reg_ack = 1'b1; reg_rdata = 16'hFFFF; fsm_req = 1'b0;
    tick();
    checks++;
    if ({fsm_ack, fsm_err, fsm_rdata, host_ack, reg_wdata} !== {2'b10, 16'h0, 1'b0, 16'h0055}) begin
      failures++; $display("FAIL t3_done got ack=%b err=%b rd=%h hack=%b wd=%h exp 1 0 0 0 0055",
        fsm_ack, fsm_err, fsm_rdata, host_ack, reg_wdata);
    end
    reg_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    host_req = 1'b1; host_addr = 8'h44; host_rnw = 1'b1;
    reg_rdata = 16'hAAAA;
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if ({host_ack, busy, grant_host} !== 3'b011) begin
        failures++; $display("FAIL t4_wait%0d got ack=%b busy=%b gh=%b exp 0 1 1", i, host_ack, busy, grant_host);
      end
    end
    tick();
    checks++;
    if ({host_ack, host_err, host_rdata, fsm_ack} !== {2'b11, 16'h0, 1'b0}) begin
      failures++; $display("FAIL t4_timeout got ack=%b err=%b rd=%h fack=%b exp 1 1 0 0", host_ack, host_err, host_rdata, fsm_ack);
    end
    host_req = 1'b0;
    tick();
    reg_ack = 1'b1;
    tick();
    checks++;
    if ({host_ack, host_err, host_rdata, fsm_ack, busy, reg_req} !== {2'b00, 16'h0, 3'b000}) begin
      failures++; $display("FAIL t4_late_ack got ack=%b err=%b rd=%h fack=%b busy=%b req=%b exp all 0",
        host_ack, host_err, host_rdata, fsm_ack, busy, reg_req);
    end
    reg_ack = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    host_req = 1'b1; host_addr = 8'h55; host_rnw = 1'b1;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({reg_req, reg_addr, grant_host, grant_fsm, busy, host_ack, host_err, host_rdata} !== 29'h0) begin
      failures++; $display("FAIL t5_async_reset got req=%b addr=%h gh=%b gf=%b busy=%b ack=%b err=%b rd=%h exp all 0",
        reg_req, reg_addr, grant_host, grant_fsm, busy, host_ack, host_err, host_rdata);
    end
    fsm_req = 1'b1; fsm_addr = 8'h31; fsm_rnw = 1'b1;
    tick(); tick();
    checks++;
    if ({host_ack, fsm_ack, busy} !== 3'b000) begin
      failures++; $display("FAIL t5_held_reset got hack=%b fack=%b busy=%b exp 000", host_ack, fsm_ack, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({grant_host, grant_fsm, reg_req, reg_addr, host_ack} !== {3'b101, 8'h55, 1'b0}) begin
      failures++; $display("FAIL t5_tie_after_reset got gh=%b gf=%b req=%b addr=%h ack=%b exp 1 0 1 55 0",
        grant_host, grant_fsm, reg_req, reg_addr, host_ack);
    end
    reg_ack = 1'b1; reg_rdata = 16'h0F0F;
    tick();
    checks++;
    if ({host_ack, host_rdata, fsm_ack} !== {1'b1, 16'h0F0F, 1'b0}) begin
      failures++; $display("FAIL t5_ack got ack=%b rd=%h fack=%b exp 1 0f0f 0", host_ack, host_rdata, fsm_ack);
    end
    host_req = 1'b0; fsm_req = 1'b0; reg_ack = 1'b0;
    tick();
  endtask

  task automatic test_operand_change();
    host_req = 1'b1; host_addr = 8'h66; host_rnw = 1'b1; host_wdata = 16'h0000;
    tick();
    tick();
    host_addr = 8'h77; host_rnw = 1'b0; host_wdata = 16'h9999;
    tick();
    checks++;
    if ({reg_addr, reg_rnw, reg_wdata, busy} !== {8'h66, 1'b1, 16'h0000, 1'b1}) begin
      failures++; $display("FAIL t6_latched got addr=%h rnw=%b wd=%h busy=%b exp 66 1 0000 1", reg_addr, reg_rnw, reg_wdata, busy);
    end
    host_req = 1'b0;
    tick();
    checks++;
    if ({busy, grant_host, reg_addr, host_ack} !== {2'b11, 8'h66, 1'b0}) begin
      failures++; $display("FAIL t6_req_dropped got busy=%b gh=%b addr=%h ack=%b exp 1 1 66 0", busy, grant_host, reg_addr, host_ack);
    end
    reg_ack = 1'b1; reg_rdata = 16'h5A5A;
    tick();
    checks++;
    if ({host_ack, host_err, host_rdata} !== {2'b10, 16'h5A5A}) begin
      failures++; $display("FAIL t6_ack got ack=%b err=%b rd=%h exp 1 0 5a5a", host_ack, host_err, host_rdata);
    end
    reg_ack = 1'b0;
    tick();
    checks++;
    if ({busy, host_ack, reg_req} !== 3'b000) begin
      failures++; $display("FAIL t6_idle got busy=%b ack=%b req=%b exp 000", busy, host_ack, reg_req);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_host_read_immediate();
    test_round_robin();
    test_fsm_write_delayed();
    test_timeout();
    test_reset_mid_wait();
    test_operand_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

- Arbitrates the single register-file access port between two requesters:
  - the I2C slave interface (host side);
  - the internal protocol state machines (Reset/Transmit/Receive side, fsm side).
- Sits between those requesters and the register block, replacing the direct `req` / `maq_est_req` connections.
- One requester at a time gets the address/RNW/write-data bus; the arbiter issues a single register request, waits for the register acknowledge (with timeout), then returns read data and a one-cycle completion pulse to the winner.

## Interface

Parameters:

- `ADDR_W`, 8, register address width
- `DATA_W`, 16, register data width
- `TIMEOUT`, 15, max cycles (1..255) to wait for `reg_ack` before aborting

Ports:

- `CLK`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `host_req`  in  1  I2C-side access request, level
- `host_addr`  in  ADDR_W  I2C-side register address
- `host_rnw`  in  1  I2C-side 1 = read, 0 = write
- `host_wdata`  in  DATA_W  I2C-side write data
- `host_ack`  out  1  I2C-side completion pulse
- `host_err`  out  1  I2C-side timeout flag, valid with `host_ack`
- `host_rdata`  out  DATA_W  I2C-side read data, valid with `host_ack`
- `fsm_req`, `fsm_addr`, `fsm_rnw`, `fsm_wdata`, `fsm_ack`, `fsm_err`, `fsm_rdata`: same as host set, for the internal-FSM requester
- `reg_req`  out  1  register-file request strobe
- `reg_addr`  out  ADDR_W  latched address to the register file
- `reg_rnw`  out  1  latched direction to the register file
- `reg_wdata`  out  DATA_W  latched write data to the register file
- `reg_rdata`  in  DATA_W  register read data, valid with `reg_ack`
- `reg_ack`  in  1  register completion
- `grant_host`, `grant_fsm`  out  1 each  one-hot ownership indicators
- `busy`  out  1  high whenever state ≠ IDLE

## Operation

- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Sample `host_req` and `fsm_req`.
  - If only one is high, grant it.
  - If both are high, grant the requester that was not granted last (round robin). `last` resets to fsm, so host wins the first tie.
  - On a grant: latch the winner's addr/rnw/wdata into `reg_addr`/`reg_rnw`/`reg_wdata`, set `last`, clear the timeout counter, and go to ISSUE.
- **ISSUE**
  - `reg_req` = 1 for exactly this cycle.
  - If `reg_ack` = 1: capture `reg_rdata` and go to DONE with err = 0.
  - Otherwise go to WAIT.
  - The counter increments in ISSUE and in every WAIT cycle.
- **WAIT**
  - If `reg_ack` = 1: capture `reg_rdata` and go to DONE with err = 0.
  - Else if counter == TIMEOUT: go to DONE with err = 1 and captured data = 0.
- **DONE**
  - The granted requester sees `*_ack` = 1 for one cycle, with `*_rdata` = captured data and `*_err` as set.
  - `*_rdata` is all-zero for writes.
  - Next state is IDLE.
- Non-granted requester's ack/err/rdata = 0 at all times.
- Requester protocol:
  - Hold req and operands stable from assertion until ack.
  - Drop req in the cycle after ack. A req still high in that IDLE cycle is treated as a new request.
- Requester inputs are ignored in ISSUE, WAIT and DONE. A req deasserted mid-transaction does not abort; the transaction completes normally.
- `reg_ack` arriving in IDLE or DONE (stray or late after timeout) is ignored and changes no output.
- Operands are latched once in IDLE, so requester changes mid-transaction have no effect on the `reg_*` bus.

## Timing

- Reset (asynchronous, immediate, including mid-transaction):
  - state = IDLE, `last` = fsm, counter = 0;
  - all outputs 0: `reg_req`, `reg_addr`, `reg_rnw`, `reg_wdata`, both ack/err/rdata sets, both grants, `busy`.
  - An in-flight transaction is dropped with no ack.
- Minimum latency, req sampled high at edge k:
  - ISSUE in cycle k+1, with `reg_req` high;
  - `reg_ack` in that same cycle gives DONE (ack) in cycle k+2;
  - IDLE in k+3.
  - Back-to-back throughput is 1 access per 3 cycles.
- Each additional cycle before `reg_ack` adds one cycle of latency.
- Timeout: with no `reg_ack`, DONE occurs TIMEOUT+1 cycles after ISSUE (ISSUE + TIMEOUT WAIT-side counts).
- `grant_*` is high from ISSUE through DONE inclusive; `busy` is identical in extent.
- All outputs are registered; no combinational path from any input to any output.

## Test plan

1. **Host read, immediate ack.** `host_req` with addr 8'h10, rnw 1; `reg_ack` in the ISSUE cycle with `reg_rdata` 16'hBEEF → `reg_req` one cycle with `reg_addr` 8'h10; `host_ack` 2 cycles after the sampling edge; `host_rdata` 16'hBEEF; `host_err` 0; `fsm_ack` stays 0.
2. **Simultaneous requests after reset.** Both req high, both held → host granted first, fsm second, host third (strict alternation). Each grant one-hot; the second `reg_req` 3 cycles after the first.
3. **FSM write, delayed ack.** addr 8'h1A, wdata 16'h0055; `reg_ack` 4 cycles after ISSUE → `reg_wdata` 16'h0055 stable throughout; `fsm_ack` one cycle after `reg_ack`; `fsm_rdata` 0.
4. **Timeout with TIMEOUT = 15.** `reg_ack` never asserted → `host_ack` = 1 with `host_err` = 1 and `host_rdata` 0, 16 cycles after ISSUE. A late `reg_ack` in the following IDLE produces no ack.
5. **Reset mid-WAIT.** Assert `reset` asynchronously → all outputs 0 immediately with no ack. Host req re-asserted after reset release wins the first tie against fsm.
6. **Operand change mid-transaction.** `host_addr` changes while in WAIT → `reg_addr` retains the originally latched value. Dropping `host_req` mid-WAIT still yields `host_ack` when `reg_ack` arrives.
